// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back over a shared datapath.
// Define MC_CTRL_JUMP_EN to build the JUMP state; without it opcode 000010 halts the CPU.
module mips_multicycle_ctrl #(
   parameter int ICNT_W = 32
) (
   input  logic              clk_CPU,
   input  logic              rst_CPU,
   input  logic [5:0]        opcode,
   input  logic              zero,
   input  logic              mem_ready,
   output logic              pc_en,
   output logic              IorD,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              IRWrite,
   output logic              RegWrite,
   output logic              MemtoReg,
   output logic              RegDst,
   output logic              ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [1:0]        ALUOp,
   output logic [1:0]        PCSource,
   output logic [3:0]        state,
   output logic              halted,
   output logic [ICNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC_R  = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9,
      S_ADDI_EX = 4'd10,
      S_ADDI_WB = 4'd11,
      S_HALT    = 4'd15
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_e            state_q, state_d;
   logic [ICNT_W-1:0] cnt_q, cnt_d;
   logic              retire;
   logic              pc_write, pc_write_cond;
   logic              mem_read_s, mem_write_s, ir_write_s, reg_write_s;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_CPU) begin
      if (rst_CPU) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d       = state_q;
      retire        = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read_s    = 1'b0;
      mem_write_s   = 1'b0;
      ir_write_s    = 1'b0;
      reg_write_s   = 1'b0;
      IorD          = 1'b0;
      MemtoReg      = 1'b0;
      RegDst        = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      ALUOp         = 2'b00;
      PCSource      = 2'b00;
      halted        = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            mem_read_s = 1'b1;
            ALUSrcB    = 2'b01;
            ir_write_s = mem_ready;
            pc_write   = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (opcode)
               OP_RTYPE:      state_d = S_EXEC_R;
               OP_LW, OP_SW:  state_d = S_MEMADR;
               OP_BEQ:        state_d = S_BRANCH;
               OP_ADDI:       state_d = S_ADDI_EX;
`ifdef MC_CTRL_JUMP_EN
               OP_J:          state_d = S_JUMP;
`endif
               default:       state_d = S_HALT;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_read_s = 1'b1;
            IorD       = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write_s = 1'b1;
            MemtoReg    = 1'b1;
            state_d     = S_FETCH;
            retire      = 1'b1;
         end
         S_MEMWR: begin
            mem_write_s = 1'b1;
            IorD        = 1'b1;
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_s = 1'b1;
            RegDst      = 1'b1;
            state_d     = S_FETCH;
            retire      = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA       = 1'b1;
            ALUOp         = 2'b01;
            pc_write_cond = 1'b1;
            PCSource      = 2'b01;
            state_d       = S_FETCH;
            retire        = 1'b1;
         end
`ifdef MC_CTRL_JUMP_EN
         S_JUMP: begin
            pc_write = 1'b1;
            PCSource = 2'b10;
            state_d  = S_FETCH;
            retire   = 1'b1;
         end
`endif
         S_ADDI_EX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            reg_write_s = 1'b1;
            state_d     = S_FETCH;
            retire      = 1'b1;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = S_HALT;
         end
      endcase

      cnt_d = cnt_q + ICNT_W'(retire);
   end

   // Reset aborts whatever access is in flight, so strobes drop in the same cycle.
   assign pc_en       = ~rst_CPU & (pc_write | (pc_write_cond & zero));
   assign MemRead     = ~rst_CPU & mem_read_s;
   assign MemWrite    = ~rst_CPU & mem_write_s;
   assign IRWrite     = ~rst_CPU & ir_write_s;
   assign RegWrite    = ~rst_CPU & reg_write_s;
   assign state       = state_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench: expected state traces are built per instruction class and compared cycle by cycle.
module tb_mips_multicycle_ctrl;

   localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3, ST_MEMWB = 4,
                  ST_MEMWR = 5, ST_EXEC_R = 6, ST_ALUWB = 7, ST_BRANCH = 8, ST_JUMP = 9,
                  ST_ADDI_EX = 10, ST_ADDI_WB = 11, ST_HALT = 15;

   logic        clk_CPU = 1'b0;
   logic        rst_CPU;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        pc_en, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, RegDst, ALUSrcA;
   logic [1:0]  ALUSrcB, ALUOp, PCSource;
   logic [3:0]  state;
   logic        halted;
   logic [31:0] instr_count;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          model_cnt = 0;
   int          q_st[$];
   bit          q_mr[$];
   logic [15:0] dut_ctrl;

   mips_multicycle_ctrl #(.ICNT_W(32)) dut (
      .clk_CPU(clk_CPU), .rst_CPU(rst_CPU), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .state(state), .halted(halted),
      .instr_count(instr_count)
   );

   always #5 clk_CPU = ~clk_CPU;

   assign dut_ctrl = {pc_en, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, RegDst,
                      ALUSrcA, ALUSrcB, ALUOp, PCSource, halted};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Control table: {pc_en,IorD,MemRead,MemWrite,IRWrite,RegWrite,MemtoReg,RegDst,ALUSrcA,ALUSrcB,ALUOp,PCSource,halted}
   function automatic logic [15:0] ref_ctrl(input int st, input bit mr, input bit z);
      case (st)
         ST_FETCH:   return {mr, 1'b0, 1'b1, 1'b0, mr, 3'b000, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
         ST_DECODE:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0};
         ST_MEMADR,
         ST_ADDI_EX: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
         ST_MEMRD:   return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
         ST_MEMWB:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
         ST_MEMWR:   return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
         ST_EXEC_R:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0};
         ST_ALUWB:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
         ST_BRANCH:  return {z,    1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0};
         ST_JUMP:    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0};
         ST_ADDI_WB: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
         ST_HALT:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1};
         default:    return 16'h0000;
      endcase
   endfunction

   function automatic void push(input int st, input bit mr);
      q_st.push_back(st);
      q_mr.push_back(mr);
   endfunction

   function automatic void push_wait(input int st, input int waits);
      for (int i = 0; i < waits; i++) push(st, 1'b0);
      push(st, 1'b1);
   endfunction

   // Expected per-cycle state trace of one instruction; retires=0 when it ends in HALT.
   task automatic build(input logic [5:0] op, input int wf, input int wm, input int nhalt,
                        output bit retires);
      q_st.delete();
      q_mr.delete();
      retires = 1'b1;
      push_wait(ST_FETCH, wf);
      push(ST_DECODE, 1'($urandom_range(0, 1)));
      case (op)
         6'b000000: begin push(ST_EXEC_R, 1'($urandom_range(0, 1))); push(ST_ALUWB, 1'($urandom_range(0, 1))); end
         6'b100011: begin push(ST_MEMADR, 1'($urandom_range(0, 1))); push_wait(ST_MEMRD, wm); push(ST_MEMWB, 1'($urandom_range(0, 1))); end
         6'b101011: begin push(ST_MEMADR, 1'($urandom_range(0, 1))); push_wait(ST_MEMWR, wm); end
         6'b000100: push(ST_BRANCH, 1'($urandom_range(0, 1)));
         6'b001000: begin push(ST_ADDI_EX, 1'($urandom_range(0, 1))); push(ST_ADDI_WB, 1'($urandom_range(0, 1))); end
`ifdef MC_CTRL_JUMP_EN
         6'b000010: push(ST_JUMP, 1'($urandom_range(0, 1)));
`endif
         default: begin
            for (int i = 0; i < nhalt; i++) push(ST_HALT, 1'($urandom_range(0, 1)));
            retires = 1'b0;
         end
      endcase
   endtask

   task automatic play(input logic [5:0] op, input int zmode);
      for (int i = 0; i < q_st.size(); i++) begin
         opcode    = op;
         mem_ready = q_mr[i];
         zero      = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         @(negedge clk_CPU);
         check($sformatf("state[%0d]", i), 32'(state), 32'(q_st[i]));
         check($sformatf("ctrl@st%0d", q_st[i]), 32'(dut_ctrl), 32'(ref_ctrl(q_st[i], q_mr[i], zero)));
         @(posedge clk_CPU);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_CPU   = 1'b1;
      mem_ready = 1'b0;
      zero      = 1'b1;
      @(negedge clk_CPU);
      check("strobes_in_reset", 32'({pc_en, MemRead, MemWrite, IRWrite, RegWrite}), 32'd0);
      @(posedge clk_CPU);
      #1;
      rst_CPU   = 1'b0;
      model_cnt = 0;
      check("reset_state", 32'(state), 32'(ST_FETCH));
      check("reset_halted", 32'(halted), 32'd0);
      check("reset_count", instr_count, 32'd0);
   endtask

   task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int nhalt,
                            input int zmode);
      bit ret;
      build(op, wf, wm, nhalt, ret);
      play(op, zmode);
      if (ret) begin
         model_cnt++;
         check("instr_count", instr_count, 32'(model_cnt));
      end else begin
         do_reset();
      end
   endtask

   // Plays a random prefix of an instruction, then resets in the middle of it.
   task automatic abort_instr(input logic [5:0] op, input int keep);
      bit ret;
      build(op, $urandom_range(0, 2), $urandom_range(1, 3), 3, ret);
      while (q_st.size() > keep) begin
         void'(q_st.pop_back());
         void'(q_mr.pop_back());
      end
      play(op, -1);
      do_reset();
   endtask

   function automatic logic [5:0] pick_illegal();
      logic [5:0] op = 6'($urandom_range(0, 63));
      if (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010}) op = 6'b111111;
      return op;
   endfunction

   initial begin
      rst_CPU   = 1'b1;
      opcode    = 6'd0;
      zero      = 1'b0;
      mem_ready = 1'b0;
      @(posedge clk_CPU);
      #1;
      do_reset();

      // Directed cases from the plan
      run_instr(6'b000000, 0, 0, 0, -1);
      run_instr(6'b100011, 0, 2, 0, -1);
      run_instr(6'b101011, 1, 0, 0, -1);
      run_instr(6'b000100, 0, 0, 0, 1);
      run_instr(6'b000100, 0, 0, 0, 0);
      run_instr(6'b001000, 0, 0, 0, -1);
      run_instr(6'b000010, 0, 0, 4, -1);
      run_instr(6'b111111, 0, 0, 10, -1);
      run_instr(6'b000000, 0, 0, 0, -1);
      abort_instr(6'b101011, 5);

      for (int n = 0; n < 200; n++) begin
         int sel = $urandom_range(0, 9);
         int wf  = $urandom_range(0, 3);
         int wm  = $urandom_range(0, 3);
         case (sel)
            0, 1:    run_instr(6'b000000, wf, wm, 0, -1);
            2:       run_instr(6'b100011, wf, wm, 0, -1);
            3:       run_instr(6'b101011, wf, wm, 0, -1);
            4:       run_instr(6'b000100, wf, wm, 0, -1);
            5:       run_instr(6'b001000, wf, wm, 0, -1);
            6:       run_instr(6'b000010, wf, wm, $urandom_range(1, 5), -1);
            7:       run_instr(pick_illegal(), wf, wm, $urandom_range(1, 5), -1);
            8:       abort_instr(6'b101011, $urandom_range(1, 5));
            default: abort_instr(6'b100011, $urandom_range(1, 5));
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
